pipe_dest_tracker: RTL and testbench
====================================

Name: pipe_dest_tracker

Overview:
- Sequential producer of the in-flight destination tags that hazard detection compares against.
- Carries each decoded instruction's destination register and write-enable from ID through EXE, MEM and WB.
- Inserts bubbles on hazard or branch flush, and holds every stage on a memory freeze.
- Also publishes a pending-write bitmap and a saturating bubble counter for debug and performance monitoring.

Parameters:
- REG_W, 4, width of a register index.
- NUM_REGS, 16, size of the architectural register file; equals 2**REG_W.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  memory stall; all stage registers and the counter hold.
- hazard  input  1  from hazard detection; the ID instruction is not admitted to EXE this cycle.
- flush  input  1  branch taken in EXE; the ID instruction is discarded.
- ID_dest  input  REG_W  destination of the instruction currently in ID.
- ID_wb_en  input  1  that instruction writes the register file.
- ID_mem_r_en  input  1  that instruction is a load.
- EXE_dest  output  REG_W  destination tag in EXE.
- EXE_wb_en  output  1  EXE entry writes back.
- EXE_mem_r_en  output  1  EXE entry is a load.
- MEM_dest  output  REG_W  destination tag in MEM.
- MEM_wb_en  output  1  MEM entry writes back.
- WB_dest  output  REG_W  destination tag in WB.
- WB_wb_en  output  1  WB entry writes back.
- pending  output  NUM_REGS  bit r set iff EXE or MEM holds a valid write to register r.
- bubble_cnt  output  CNT_W  number of bubbles inserted since reset; saturating.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All *_dest outputs are 0; all *_wb_en and EXE_mem_r_en are 0.
  - pending = 0 and bubble_cnt = 0.
  - rst overrides freeze, hazard and flush.
- Priority: rst > freeze > (hazard | flush) > normal advance.
- freeze=1: EXE, MEM, WB registers and bubble_cnt hold their values; hazard and flush are ignored that cycle. A source whose flush coincides with freeze must keep flush asserted until freeze drops.
- Normal advance, every non-frozen edge:
  - WB <= MEM.
  - MEM <= EXE; EXE_mem_r_en is dropped at this hop.
  - EXE <= {ID_dest, ID_wb_en, ID_mem_r_en}.
- Bubble (hazard=1 or flush=1, no freeze):
  - EXE <= {dest=0, wb_en=0, mem_r_en=0}.
  - MEM and WB still advance.
  - bubble_cnt increments by exactly 1, even if hazard and flush are both high.
- bubble_cnt saturates at 2**CNT_W-1 and does not wrap.
- Bubble entries always carry dest=0 so waveforms are deterministic; consumers qualify every dest with its wb_en.
- pending is combinational from registered state:
  - Computed as (EXE_wb_en ? onehot(EXE_dest) : 0) | (MEM_wb_en ? onehot(MEM_dest) : 0).
  - WB is excluded because the register file writes on the first half-cycle.
- Latency: an ID entry reaches EXE 1 cycle after admission, MEM after 2, WB after 3. Frozen cycles add one cycle each.
- Same dest in EXE and MEM: the pending bit is simply set; no counting.
- All outputs are registered or derived purely from registered state, with no combinational path from inputs to outputs.

Decomposition:
- Shared package: REG_W, NUM_REGS, and a stage-tag struct {dest, wb_en}.
- The register-index-to-onehot function also belongs in the package.
- One natural sub-module: dest_stage_reg, a single tag register with rst, hold (freeze) and clear (bubble) inputs.
  - Instantiated three times for EXE, MEM and WB.
  - Only the EXE instance ties clear to hazard|flush.

Test Plan:
- Reset then stream: rst for 2 cycles, then ID_dest=3,5,7 with wb_en=1 on consecutive cycles.
  - After 3 edges: EXE_dest=7, MEM_dest=5, WB_dest=3, all wb_en=1.
  - pending=16'h00A0; bubble_cnt=0.
- Load-use bubble: EXE holds a load to R2, hazard=1 for 1 cycle with ID_dest=4.
  - Next edge: EXE_wb_en=0, EXE_dest=0, MEM_dest=2 with MEM_wb_en=1, bubble_cnt=1.
  - Following edge: EXE_dest=4.
- Freeze hold: pipeline holds 1/2/3 and freeze=1 for 3 cycles with hazard=1 and new ID_dest=9.
  - All stage outputs and bubble_cnt are unchanged throughout.
  - When freeze drops with hazard still 1: bubble inserted and bubble_cnt+1.
- Simultaneous hazard and flush: both high for one cycle.
  - Exactly one bubble inserted; bubble_cnt increases by 1, not 2.
- Counter saturation: force 2**CNT_W+3 bubbles (use CNT_W=4 in the bench, i.e. 19 bubbles).
  - bubble_cnt stops at 15.
- Mid-operation reset: pipeline full with pending=16'h0006, assert rst with freeze=1.
  - Next edge: every output is 0, proving rst beats freeze.

Source files
------------

// File: rtl/pipe_dest_tracker_pkg.sv
// pipe_dest_tracker_pkg: shared widths, stage tag type and register one-hot helper
package pipe_dest_tracker_pkg;
  localparam int REG_W = 4;
  localparam int NUM_REGS = 2 ** REG_W;
  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wb_en;
  } stage_tag_t;
  localparam stage_tag_t TAG_NONE = '0;
  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_W-1:0] r);
    onehot = '0;
    onehot[r] = 1'b1;
  endfunction
endpackage

// File: rtl/pipe_dest_tracker_stage.sv
// dest_stage_reg: one pipeline tag register with hold and bubble-clear
module dest_stage_reg
  import pipe_dest_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             clear,
  input  logic [REG_W-1:0] d_dest,
  input  logic             d_wb_en,
  output logic [REG_W-1:0] q_dest,
  output logic             q_wb_en
);
  stage_tag_t tag_d, tag_q;
  // hold wins over clear; a cleared entry is a zero-dest bubble
  always_comb tag_d = hold ? tag_q : clear ? TAG_NONE : '{dest: d_dest, wb_en: d_wb_en};
  // tag register, reset to an empty entry
  always_ff @(posedge clk) tag_q <= rst ? TAG_NONE : tag_d;
  assign q_dest  = tag_q.dest;
  assign q_wb_en = tag_q.wb_en;
endmodule

// File: rtl/pipe_dest_tracker.sv
// pipe_dest_tracker: in-flight destination tags ID->EXE->MEM->WB with bubbles, freeze and debug counters
module pipe_dest_tracker
  import pipe_dest_tracker_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                hazard,
  input  logic                flush,
  input  logic [REG_W-1:0]    ID_dest,
  input  logic                ID_wb_en,
  input  logic                ID_mem_r_en,
  output logic [REG_W-1:0]    EXE_dest,
  output logic                EXE_wb_en,
  output logic                EXE_mem_r_en,
  output logic [REG_W-1:0]    MEM_dest,
  output logic                MEM_wb_en,
  output logic [REG_W-1:0]    WB_dest,
  output logic                WB_wb_en,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    bubble_cnt
);
  logic             bubble;
  logic             mem_r_en_d, mem_r_en_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  assign bubble = hazard | flush;
  dest_stage_reg u_exe (
    .clk(clk), .rst(rst), .hold(freeze), .clear(bubble),
    .d_dest(ID_dest), .d_wb_en(ID_wb_en),
    .q_dest(EXE_dest), .q_wb_en(EXE_wb_en)
  );
  dest_stage_reg u_mem (
    .clk(clk), .rst(rst), .hold(freeze), .clear(1'b0),
    .d_dest(EXE_dest), .d_wb_en(EXE_wb_en),
    .q_dest(MEM_dest), .q_wb_en(MEM_wb_en)
  );
  dest_stage_reg u_wb (
    .clk(clk), .rst(rst), .hold(freeze), .clear(1'b0),
    .d_dest(MEM_dest), .d_wb_en(MEM_wb_en),
    .q_dest(WB_dest), .q_wb_en(WB_wb_en)
  );
  // load flag lives only in EXE; it is dropped on the hop to MEM
  always_comb mem_r_en_d = freeze ? mem_r_en_q : bubble ? 1'b0 : ID_mem_r_en;
  // one count per bubbled cycle, saturating at all-ones
  always_comb cnt_d = (freeze || !bubble || &cnt_q) ? cnt_q : cnt_q + 1'b1;
  // EXE load flag and bubble counter registers
  always_ff @(posedge clk) begin
    mem_r_en_q <= rst ? 1'b0 : mem_r_en_d;
    cnt_q      <= rst ? '0 : cnt_d;
  end
  assign EXE_mem_r_en = mem_r_en_q;
  assign bubble_cnt   = cnt_q;
  assign pending = (EXE_wb_en ? onehot(EXE_dest) : '0) | (MEM_wb_en ? onehot(MEM_dest) : '0);
endmodule

// File: tb/tb_pipe_dest_tracker.sv
// tb_pipe_dest_tracker: directed checks of the destination tag pipeline
module tb_pipe_dest_tracker;
  logic        clk = 0, rst = 1, freeze = 0, hazard = 0, flush = 0;
  logic [3:0]  ID_dest = 0;
  logic        ID_wb_en = 0, ID_mem_r_en = 0;
  logic [3:0]  EXE_dest, MEM_dest, WB_dest;
  logic        EXE_wb_en, EXE_mem_r_en, MEM_wb_en, WB_wb_en;
  logic [15:0] pending;
  logic [3:0]  bubble_cnt;
  int checks = 0, errors = 0;

  pipe_dest_tracker #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .hazard(hazard), .flush(flush),
    .ID_dest(ID_dest), .ID_wb_en(ID_wb_en), .ID_mem_r_en(ID_mem_r_en),
    .EXE_dest(EXE_dest), .EXE_wb_en(EXE_wb_en), .EXE_mem_r_en(EXE_mem_r_en),
    .MEM_dest(MEM_dest), .MEM_wb_en(MEM_wb_en),
    .WB_dest(WB_dest), .WB_wb_en(WB_wb_en),
    .pending(pending), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stages(input string tag,
                            input logic [3:0] ed, input logic ew,
                            input logic [3:0] md, input logic mw,
                            input logic [3:0] wd, input logic ww);
    chk({tag, "_exe_dest"}, 32'(EXE_dest), 32'(ed));
    chk({tag, "_exe_wb"},   32'(EXE_wb_en), 32'(ew));
    chk({tag, "_mem_dest"}, 32'(MEM_dest), 32'(md));
    chk({tag, "_mem_wb"},   32'(MEM_wb_en), 32'(mw));
    chk({tag, "_wb_dest"},  32'(WB_dest), 32'(wd));
    chk({tag, "_wb_wb"},    32'(WB_wb_en), 32'(ww));
  endtask

  task automatic feed(input logic [3:0] d, input logic w, input logic m);
    ID_dest = d; ID_wb_en = w; ID_mem_r_en = m;
    tick();
  endtask

  initial begin
    tick(); tick();
    chk_stages("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_mem_r", 32'(EXE_mem_r_en), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_cnt", 32'(bubble_cnt), 0);
    rst = 0;

    feed(3, 1, 0); feed(5, 1, 0); feed(7, 1, 0);
    chk_stages("stream", 7, 1, 5, 1, 3, 1);
    chk("stream_pending", 32'(pending), 32'h00A0);
    chk("stream_cnt", 32'(bubble_cnt), 0);

    feed(2, 1, 1);
    chk("load_mem_r", 32'(EXE_mem_r_en), 1);
    hazard = 1;
    feed(4, 1, 0);
    chk_stages("bubble", 0, 0, 2, 1, 7, 1);
    chk("bubble_mem_r", 32'(EXE_mem_r_en), 0);
    chk("bubble_pending", 32'(pending), 32'h0004);
    chk("bubble_cnt", 32'(bubble_cnt), 1);
    hazard = 0;
    feed(4, 1, 0);
    chk_stages("after_bubble", 4, 1, 0, 0, 2, 1);
    chk("after_bubble_pending", 32'(pending), 32'h0010);

    feed(3, 1, 0); feed(2, 1, 0); feed(1, 1, 0);
    chk_stages("pre_freeze", 1, 1, 2, 1, 3, 1);
    chk("pre_freeze_pending", 32'(pending), 32'h0006);
    freeze = 1; hazard = 1;
    for (int i = 0; i < 3; i++) begin
      feed(9, 1, 1);
      chk_stages("freeze", 1, 1, 2, 1, 3, 1);
      chk("freeze_mem_r", 32'(EXE_mem_r_en), 0);
      chk("freeze_cnt", 32'(bubble_cnt), 1);
    end
    freeze = 0;
    feed(9, 1, 1);
    chk_stages("unfreeze", 0, 0, 1, 1, 2, 1);
    chk("unfreeze_cnt", 32'(bubble_cnt), 2);

    hazard = 1; flush = 1;
    feed(6, 1, 0);
    chk_stages("hz_fl", 0, 0, 0, 0, 1, 1);
    chk("hz_fl_cnt", 32'(bubble_cnt), 3);
    flush = 0;

    for (int i = 0; i < 11; i++) feed(8, 1, 0);
    chk("sat_mid_cnt", 32'(bubble_cnt), 14);
    for (int i = 0; i < 8; i++) feed(8, 1, 0);
    chk("sat_cnt", 32'(bubble_cnt), 15);
    chk("sat_exe_wb", 32'(EXE_wb_en), 0);
    hazard = 0;

    feed(1, 1, 0); feed(2, 1, 1);
    chk("full_pending", 32'(pending), 32'h0006);
    chk("full_mem_r", 32'(EXE_mem_r_en), 1);
    rst = 1; freeze = 1;
    feed(5, 1, 1);
    chk_stages("rst_freeze", 0, 0, 0, 0, 0, 0);
    chk("rst_freeze_mem_r", 32'(EXE_mem_r_en), 0);
    chk("rst_freeze_pending", 32'(pending), 0);
    chk("rst_freeze_cnt", 32'(bubble_cnt), 0);
    rst = 0; freeze = 0;
    feed(11, 1, 0);
    chk_stages("post_rst", 11, 1, 0, 0, 0, 0);
    chk("post_rst_pending", 32'(pending), 32'h0800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
